switch_core_rr: RTL and testbench

- Parametrised NUM_PORTS x NUM_PORTS single-beat packet switch core. Next generation of the fixed 4-port dut_top.
- Each input has a FIFO. Each output has a round-robin arbiter and a registered output stage that honours backpressure.
- Sits between the downstream (input) and upstream (output) interface arrays. The routing destination is carried in the top bits of each beat.

---
 rtl/switch_core_rr_if.sv | 24 ++
 rtl/switch_core_rr.sv | 120 ++++++++++++
 tb/tb_switch_core_rr.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_core_rr_if.sv
// Handshake bundle between the input/output port arrays and the switch core.
// The core takes the slave view; the surrounding fabric (or a bench) takes master.
interface switch_core_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8
);
  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [NUM_PORTS-1:0]        out_valid;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0]        out_ready;
  logic [NUM_PORTS-1:0]        dest_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, dest_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, dest_err
  );
endinterface

// File: rtl/switch_core_rr.sv
// NUM_PORTS x NUM_PORTS single-beat switch: per-input FIFO, per-output round-robin
// arbiter feeding a one-entry registered output stage with backpressure.
module switch_core_rr #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DEST_W     = $clog2(NUM_PORTS)
) (
  input  logic            clk,
  input  logic            reset,
  switch_core_rr_if.slave bus
);
  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]  ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);
  localparam logic [DEST_W-1:0] RR_INIT = DEST_W'(NUM_PORTS-1);

  logic [DATA_W-1:0] mem_q     [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q   [NUM_PORTS];
  logic [PTR_W-1:0]  rdPtr_q   [NUM_PORTS];
  logic [PTR_W:0]    count_q   [NUM_PORTS];
  logic [DATA_W-1:0] outData_q [NUM_PORTS];
  logic [DATA_W-1:0] outData_d [NUM_PORTS];
  logic [DEST_W-1:0] rrPtr_q   [NUM_PORTS];
  logic [DEST_W-1:0] rrPtr_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] outValid_q, outValid_d;
  logic [NUM_PORTS-1:0] destErr_q;

  logic [NUM_PORTS-1:0] inReady, accept, push, pop, notEmpty, sel;
  logic [DATA_W-1:0]    inBeat   [NUM_PORTS];
  logic [DATA_W-1:0]    head     [NUM_PORTS];
  logic [DEST_W-1:0]    inDest   [NUM_PORTS];
  logic [DEST_W-1:0]    headDest [NUM_PORTS];
  logic [DEST_W-1:0]    cand;

  // in_ready depends only on registered occupancy, so a same-cycle pop on a
  // full FIFO does not reopen it until the following cycle.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      inBeat[i]   = bus.in_data[i*DATA_W +: DATA_W];
      inDest[i]   = inBeat[i][DATA_W-1 -: DEST_W];
      inReady[i]  = (count_q[i] != FULL_CNT);
      notEmpty[i] = (count_q[i] != '0);
      accept[i]   = bus.in_valid[i] && inReady[i];
      push[i]     = accept[i] && (int'(inDest[i]) < NUM_PORTS);
      head[i]     = mem_q[i][rdPtr_q[i]];
      headDest[i] = head[i][DATA_W-1 -: DEST_W];
    end
  end

  // Scanning from the farthest candidate down lets the nearest requester after
  // rrPtr overwrite the others, so the last match is the round-robin winner.
  always_comb begin
    pop        = '0;
    sel        = '0;
    cand       = '0;
    outValid_d = outValid_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      outData_d[j] = outData_q[j];
      rrPtr_d[j]   = rrPtr_q[j];
      if (!outValid_q[j] || bus.out_ready[j]) begin
        outValid_d[j] = 1'b0;
        outData_d[j]  = '0;
        sel           = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
          cand = DEST_W'((int'(rrPtr_q[j]) + k) % NUM_PORTS);
          if (notEmpty[cand] && (int'(headDest[cand]) == j)) begin
            outValid_d[j] = 1'b1;
            outData_d[j]  = head[cand];
            rrPtr_d[j]    = cand;
            sel           = '0;
            sel[cand]     = 1'b1;
          end
        end
        pop = pop | sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wrPtr_q[i]   <= '0;
        rdPtr_q[i]   <= '0;
        count_q[i]   <= '0;
        outData_q[i] <= '0;
        rrPtr_q[i]   <= RR_INIT;
      end
      outValid_q <= '0;
      destErr_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wrPtr_q[i] <= wrPtr_q[i] + ONE_PTR;
        if (pop[i])  rdPtr_q[i] <= rdPtr_q[i] + ONE_PTR;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + ONE_CNT;
        else if (!push[i] && pop[i]) count_q[i] <= count_q[i] - ONE_CNT;
        outData_q[i] <= outData_d[i];
        rrPtr_q[i]   <= rrPtr_d[i];
      end
      outValid_q <= outValid_d;
      destErr_q  <= accept & ~push;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) mem_q[i][wrPtr_q[i]] <= inBeat[i];
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.dest_err  = destErr_q;

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    assign bus.out_data[j*DATA_W +: DATA_W] = outData_q[j];
  end
endmodule

// File: tb/tb_switch_core_rr.sv
// Bench for switch_core_rr: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based model of the switching rules.
module tb_switch_core_rr;
  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstN;
  logic [NP-1:0]    inValid, outReady;
  logic [NP*DW-1:0] inData;
  logic [2:0]       inValid3, outReady3;
  logic [3*DW-1:0]  inData3;

  int total = 0;
  int bad   = 0;

  logic [7:0]    mq [NP][$];
  logic [7:0]    rxQ[NP][$];
  logic [NP-1:0] mValid, mAccept;
  logic [7:0]    mData[NP];
  int            lastGrant[NP];
  int            accCount, rxCount, nextC;
  logic [7:0]    expOrder[4];

  switch_core_rr_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus4 ();
  switch_core_rr_if #(.NUM_PORTS(3),  .DATA_W(DW)) bus3 ();

  assign bus4.in_valid  = inValid;
  assign bus4.in_data   = inData;
  assign bus4.out_ready = outReady;
  assign bus3.in_valid  = inValid3;
  assign bus3.in_data   = inData3;
  assign bus3.out_ready = outReady3;

  switch_core_rr #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rstN),
    .bus   (bus4)
  );

  switch_core_rr #(.NUM_PORTS(3), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut3 (
    .clk   (clk),
    .reset (rstN),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      mData[i]     = 8'h00;
      lastGrant[i] = NP - 1;
    end
    mValid = '0;
  endtask

  // One clock of the switching rules: arbitrate on the pre-edge heads, then
  // append whatever the inputs handed over on this edge.
  task automatic modelStep();
    logic       hv[NP];
    logic [1:0] hd[NP];
    int         g, c;
    for (int i = 0; i < NP; i++) begin
      hv[i]      = (mq[i].size() > 0);
      hd[i]      = hv[i] ? mq[i][0][7:6] : 2'd0;
      mAccept[i] = inValid[i] && (mq[i].size() < DEPTH);
    end
    for (int j = 0; j < NP; j++) begin
      if (!mValid[j] || outReady[j]) begin
        g = -1;
        for (int k = 1; k <= NP; k++) begin
          c = (lastGrant[j] + k) % NP;
          if (g < 0 && hv[c] && int'(hd[c]) == j) g = c;
        end
        if (g >= 0) begin
          mData[j]     = mq[g].pop_front();
          mValid[j]    = 1'b1;
          lastGrant[j] = g;
        end else begin
          mData[j]  = 8'h00;
          mValid[j] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (mAccept[i]) begin
        mq[i].push_back(inData[i*DW +: DW]);
        accCount++;
      end
    end
  endtask

  task automatic checkModel();
    logic [NP-1:0]    expReady;
    logic [NP*DW-1:0] expData;
    for (int i = 0; i < NP; i++) begin
      expReady[i]          = (mq[i].size() < DEPTH);
      expData[i*DW +: DW]  = mData[i];
    end
    checkOutput("out_valid", 32'(bus4.out_valid), 32'(mValid));
    checkOutput("out_data",  bus4.out_data, expData);
    checkOutput("in_ready",  32'(bus4.in_ready), 32'(expReady));
    checkOutput("dest_err",  32'(bus4.dest_err), 32'h0);
  endtask

  // Beats leaving the switch are logged just before the edge that takes them.
  task automatic applyStimulus();
    for (int j = 0; j < NP; j++) begin
      if (bus4.out_valid[j] && outReady[j]) begin
        rxQ[j].push_back(bus4.out_data[j*DW +: DW]);
        rxCount++;
      end
    end
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
  endtask

  task automatic idle(input int n);
    inValid = '0;
    for (int c = 0; c < n; c++) applyStimulus();
  endtask

  task automatic clearRx();
    for (int j = 0; j < NP; j++) rxQ[j].delete();
    rxCount  = 0;
    accCount = 0;
  endtask

  initial begin
    rstN      = 1'b0;
    inValid   = '0;
    inData    = '0;
    outReady  = '1;
    inValid3  = '0;
    inData3   = '0;
    outReady3 = '1;
    accCount  = 0;
    rxCount   = 0;
    modelReset();

    #12;
    checkOutput("reset_out_valid", 32'(bus4.out_valid), 32'h0);
    checkOutput("reset_out_data",  bus4.out_data, 32'h0);
    checkOutput("reset_dest_err",  32'(bus4.dest_err), 32'h0);
    rstN = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(bus4.in_ready), 32'hF);

    // Single beat to output 2: valid only after the second edge.
    clearRx();
    inValid     = 4'b0001;
    inData[7:0] = 8'h85;
    applyStimulus();
    checkOutput("t1_e0_valid", 32'(bus4.out_valid), 32'h0);
    inValid = '0;
    applyStimulus();
    checkOutput("t1_e1_valid", 32'(bus4.out_valid), 32'h4);
    checkOutput("t1_e1_data",  32'(bus4.out_data[23:16]), 32'h85);
    idle(3);

    // Four-way contention on output 1, starting from the reset pointer.
    clearRx();
    inValid = 4'hF;
    inData  = {8'h43, 8'h42, 8'h41, 8'h40};
    applyStimulus();
    idle(6);
    expOrder = '{8'h40, 8'h41, 8'h42, 8'h43};
    checkOutput("t2_count", 32'(rxQ[1].size()), 32'd4);
    for (int k = 0; k < 4; k++) checkOutput("t2_order", 32'(rxQ[1][k]), 32'(expOrder[k]));

    // Move the output 1 pointer to input 0, then contend again.
    inValid     = 4'b0001;
    inData[7:0] = 8'h40;
    applyStimulus();
    idle(3);
    clearRx();
    inValid = 4'hF;
    inData  = {8'h43, 8'h42, 8'h41, 8'h40};
    applyStimulus();
    idle(6);
    expOrder = '{8'h41, 8'h42, 8'h43, 8'h40};
    checkOutput("t2b_count", 32'(rxQ[1].size()), 32'd4);
    for (int k = 0; k < 4; k++) checkOutput("t2b_order", 32'(rxQ[1][k]), 32'(expOrder[k]));

    // Backpressure on output 3 while input 2 streams.
    clearRx();
    outReady = 4'b0111;
    nextC    = 0;
    for (int c = 0; c < 8; c++) begin
      inValid        = 4'b0100;
      inData[23:16]  = 8'hC0 + 8'(nextC);
      applyStimulus();
      if (mAccept[2]) nextC++;
    end
    checkOutput("t3_accepted", 32'(nextC), 32'd5);
    checkOutput("t3_in_ready", 32'(bus4.in_ready[2]), 32'h0);
    checkOutput("t3_held_vld", 32'(bus4.out_valid[3]), 32'h1);
    checkOutput("t3_held_dat", 32'(bus4.out_data[31:24]), 32'hC0);
    outReady = '1;
    for (int c = 0; c < 20; c++) begin
      inValid       = (nextC < 8) ? 4'b0100 : 4'b0000;
      inData[23:16] = 8'hC0 + 8'(nextC);
      applyStimulus();
      if (mAccept[2]) nextC++;
    end
    checkOutput("t3_count", 32'(rxQ[3].size()), 32'd8);
    for (int k = 0; k < 8; k++) checkOutput("t3_order", 32'(rxQ[3][k]), 32'hC0 + 32'(k));

    // Cyclic permutation at full rate: every output busy every cycle.
    clearRx();
    for (int c = 0; c < 20; c++) begin
      inValid = 4'hF;
      for (int i = 0; i < NP; i++) inData[i*DW +: DW] = {2'((i + 1) % NP), 6'(c)};
      applyStimulus();
      if (c >= 1) checkOutput("t4_all_valid", 32'(bus4.out_valid), 32'hF);
    end
    idle(4);
    checkOutput("t4_accepted", 32'(accCount), 32'd80);
    checkOutput("t4_no_loss",  32'(rxCount), 32'(accCount));

    // Random traffic with random sink stalls.
    for (int c = 0; c < 400; c++) begin
      inValid  = 4'($urandom);
      inData   = $urandom;
      outReady = 4'($urandom) | 4'($urandom);
      applyStimulus();
    end
    outReady = '1;
    idle(12);

    // Asynchronous reset with three beats buffered and one on the output.
    outReady = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      inValid       = 4'b1000;
      inData[31:24] = 8'(k);
      applyStimulus();
    end
    inValid = '0;
    applyStimulus();
    checkOutput("t5_pre_valid", 32'(bus4.out_valid[0]), 32'h1);
    #4;
    rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("t5_async_valid", 32'(bus4.out_valid), 32'h0);
    checkOutput("t5_async_data",  bus4.out_data, 32'h0);
    #2;
    rstN     = 1'b1;
    outReady = '1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("t5_quiet", 32'(bus4.out_valid), 32'h0);
    end

    // Three-port core: destination 3 is out of range.
    inValid3       = 3'b010;
    inData3[15:8]  = 8'hC5;
    applyStimulus();
    checkOutput("t6_dest_err", 32'(bus3.dest_err), 32'h2);
    checkOutput("t6_in_ready", 32'(bus3.in_ready), 32'h7);
    checkOutput("t6_no_valid", 32'(bus3.out_valid), 32'h0);
    inValid3 = '0;
    applyStimulus();
    checkOutput("t6_err_pulse", 32'(bus3.dest_err), 32'h0);
    checkOutput("t6_no_valid2", 32'(bus3.out_valid), 32'h0);
    applyStimulus();
    checkOutput("t6_no_valid3", 32'(bus3.out_valid), 32'h0);
    inValid3      = 3'b010;
    inData3[15:8] = 8'h45;
    applyStimulus();
    inValid3 = '0;
    checkOutput("t6_good_e0", 32'(bus3.out_valid), 32'h0);
    applyStimulus();
    checkOutput("t6_good_vld", 32'(bus3.out_valid), 32'h2);
    checkOutput("t6_good_dat", 32'(bus3.out_data[15:8]), 32'h45);
    checkOutput("t6_good_err", 32'(bus3.dest_err), 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
